instr_cache_refill: RTL and testbench

Miss handler and block writer for the N-way instruction cache. It accepts a miss address from the fetch-side cache lookup and reads the missing block from instruction memory one word at a time. It then presents a complete block (tag, index, victim way, data) for a one-cycle write into the cache array. It sits between the IF-stage cache and the instruction memory port, and forwards the critical instruction to the fetch stage as soon as it arrives.

---
 rtl/instr_cache_refill_if.sv | 46 ++++
 rtl/instr_cache_refill.sv | 155 +++++++++++++++
 tb/tb_instr_cache_refill.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_cache_refill_if.sv
// Bundle of miss, memory-port, fill and critical-word signals for instr_cache_refill.
// master = the refill engine, slave = the surrounding cache/memory environment.
interface instr_cache_refill_if #(
    parameter int unsigned ADDRESS_WIDTH   = 32,
    parameter int unsigned N               = 4,
    parameter int unsigned WORDS_PER_BLOCK = 4,
    parameter int unsigned NUM_BLOCKS      = 16,
    parameter int unsigned WORD_SIZE       = 4
) ();
    localparam int unsigned NUM_SETS = NUM_BLOCKS / N;
    localparam int unsigned WW       = WORD_SIZE * 8;
    localparam int unsigned IDX      = $clog2(NUM_SETS);
    localparam int unsigned BOFF     = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned BYOFF    = $clog2(WORD_SIZE);
    localparam int unsigned TAG      = ADDRESS_WIDTH - IDX - BOFF - BYOFF;
    localparam int unsigned WAYB     = (N > 1) ? $clog2(N) : 1;

    logic                          miss_req;
    logic [ADDRESS_WIDTH-1:0]      miss_addr;
    logic [N-1:0]                  set_valid;
    logic                          miss_ready;
    logic                          mem_req_valid;
    logic [ADDRESS_WIDTH-1:0]      mem_req_addr;
    logic                          mem_req_ready;
    logic                          mem_resp_valid;
    logic [WW-1:0]                 mem_resp_data;
    logic                          fill_valid;
    logic [IDX-1:0]                fill_index;
    logic [WAYB-1:0]               fill_way;
    logic [TAG-1:0]                fill_tag;
    logic [WORDS_PER_BLOCK*WW-1:0] fill_data;
    logic                          crit_valid;
    logic [WW-1:0]                 crit_instr;

    modport master (
        input  miss_req, miss_addr, set_valid, mem_req_ready, mem_resp_valid, mem_resp_data,
        output miss_ready, mem_req_valid, mem_req_addr, fill_valid, fill_index, fill_way,
               fill_tag, fill_data, crit_valid, crit_instr
    );

    modport slave (
        output miss_req, miss_addr, set_valid, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  miss_ready, mem_req_valid, mem_req_addr, fill_valid, fill_index, fill_way,
               fill_tag, fill_data, crit_valid, crit_instr
    );
endinterface

// File: rtl/instr_cache_refill.sv
// I-cache miss handler: fetches a block word by word, then issues a one-cycle fill.
// Define CRIT_WORD_FIRST_EN to start at the missed word and forward it early.
module instr_cache_refill #(
    parameter int unsigned ADDRESS_WIDTH   = 32,
    parameter int unsigned N               = 4,
    parameter int unsigned WORDS_PER_BLOCK = 4,
    parameter int unsigned NUM_BLOCKS      = 16,
    parameter int unsigned WORD_SIZE       = 4
) (
    input logic                  clk,
    input logic                  reset,
    instr_cache_refill_if.master bus
);
    localparam int unsigned NUM_SETS = NUM_BLOCKS / N;
    localparam int unsigned WW       = WORD_SIZE * 8;
    localparam int unsigned IDX      = $clog2(NUM_SETS);
    localparam int unsigned BOFF     = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned BYOFF    = $clog2(WORD_SIZE);
    localparam int unsigned TAG      = ADDRESS_WIDTH - IDX - BOFF - BYOFF;
    localparam int unsigned WAYB     = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_FILL} state_e;

    state_e          state_q, state_d;
    logic [TAG-1:0]  tag_q;
    logic [IDX-1:0]  idx_q;
    logic [BOFF-1:0] woff_q, k_q, cnt_q;
    logic [WAYB-1:0] way_q;
    logic            use_rr_q;
    logic [WW-1:0]   buf_q [WORDS_PER_BLOCK];

    logic                          accept, resp_fire, last_word, all_valid;
    logic [IDX-1:0]                miss_idx;
    logic [BOFF-1:0]               start_word;
    logic [WAYB-1:0]               rr_cur, victim;
    logic [WORDS_PER_BLOCK*WW-1:0] fill_data_w;
    logic                          unused_byteoff;

    assign accept         = bus.miss_req && (state_q == S_IDLE);
    assign resp_fire      = (state_q == S_RESP) && bus.mem_resp_valid;
    assign last_word      = (cnt_q == BOFF'(WORDS_PER_BLOCK - 1));
    assign miss_idx       = bus.miss_addr[BYOFF+BOFF +: IDX];
    assign all_valid      = &bus.set_valid;
    assign unused_byteoff = ^bus.miss_addr[BYOFF-1:0];

`ifdef CRIT_WORD_FIRST_EN
    assign start_word = bus.miss_addr[BYOFF +: BOFF];
`else
    assign start_word = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept)            state_d = S_REQ;
            S_REQ:  if (bus.mem_req_ready) state_d = S_RESP;
            S_RESP: if (bus.mem_resp_valid) state_d = last_word ? S_FILL : S_REQ;
            S_FILL:                        state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    // Lowest invalid way wins; the round-robin pointer only matters for a full set.
    always_comb begin
        victim = rr_cur;
        for (int unsigned i = N; i > 0; i--) begin
            if (!bus.set_valid[i-1]) victim = WAYB'(i - 1);
        end
    end

    if (N > 1) begin : g_rr
        logic [WAYB-1:0] rr_q [NUM_SETS];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int unsigned s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
            end else if (state_q == S_FILL && use_rr_q) begin
                rr_q[idx_q] <= (rr_q[idx_q] == WAYB'(N - 1)) ? '0 : rr_q[idx_q] + 1'b1;
            end
        end

        assign rr_cur = rr_q[miss_idx];
    end else begin : g_no_rr
        assign rr_cur = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q    <= '0;
            idx_q    <= '0;
            woff_q   <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            way_q    <= '0;
            use_rr_q <= 1'b0;
            for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++) buf_q[w] <= '0;
        end else begin
            if (accept) begin
                tag_q    <= bus.miss_addr[ADDRESS_WIDTH-1 -: TAG];
                idx_q    <= miss_idx;
                woff_q   <= bus.miss_addr[BYOFF +: BOFF];
                k_q      <= start_word;
                cnt_q    <= '0;
                way_q    <= victim;
                use_rr_q <= all_valid;
            end
            // k wraps naturally because WORDS_PER_BLOCK is a power of two.
            if (resp_fire) begin
                buf_q[k_q] <= bus.mem_resp_data;
                k_q        <= k_q + 1'b1;
                cnt_q      <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        fill_data_w = '0;
        for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++) fill_data_w[w*WW +: WW] = buf_q[w];
    end

    assign bus.miss_ready    = (state_q == S_IDLE);
    assign bus.mem_req_valid = (state_q == S_REQ);
    assign bus.mem_req_addr  = (state_q == S_REQ) ? {tag_q, idx_q, k_q, {BYOFF{1'b0}}} : '0;
    assign bus.fill_valid    = (state_q == S_FILL);
    assign bus.fill_index    = idx_q;
    assign bus.fill_way      = way_q;
    assign bus.fill_tag      = tag_q;
    assign bus.fill_data     = fill_data_w;

`ifdef CRIT_WORD_FIRST_EN
    logic          crit_valid_q;
    logic [WW-1:0] crit_instr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            crit_valid_q <= 1'b0;
            crit_instr_q <= '0;
        end else begin
            crit_valid_q <= resp_fire && (cnt_q == '0);
            if (resp_fire && cnt_q == '0) crit_instr_q <= bus.mem_resp_data;
        end
    end

    assign bus.crit_valid = crit_valid_q;
    assign bus.crit_instr = crit_instr_q;
`else
    assign bus.crit_valid = (state_q == S_FILL);
    assign bus.crit_instr = (state_q == S_FILL) ? buf_q[woff_q] : '0;
`endif
endmodule

// File: tb/tb_instr_cache_refill.sv
// Directed bench for instr_cache_refill with a data=address memory model.
// Expectations follow CRIT_WORD_FIRST_EN when the bench is built with it.
module tb_instr_cache_refill;
`ifdef CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;

    instr_cache_refill_if #(
        .ADDRESS_WIDTH(32), .N(4), .WORDS_PER_BLOCK(4), .NUM_BLOCKS(16), .WORD_SIZE(4)
    ) bus ();

    instr_cache_refill #(
        .ADDRESS_WIDTH(32), .N(4), .WORDS_PER_BLOCK(4), .NUM_BLOCKS(16), .WORD_SIZE(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Memory model state, shared with the stimulus process.
    int          ready_delay, resp_delay;
    int          wait_cnt, resp_timer;
    int          req_cnt, resp_cnt, first_req_cyc, first_resp_cyc, last_resp_cyc;
    logic [31:0] req_log [16];
    logic [31:0] pend_addr, held_addr;

    initial begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        wait_cnt = 0; resp_timer = 0; ready_delay = 0; resp_delay = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                resp_timer = 0;
                wait_cnt   = 0;
                bus.mem_req_ready  = 1'b0;
                bus.mem_resp_valid = 1'b0;
            end else begin
                bus.mem_resp_valid = 1'b0;
                if (resp_timer > 0) begin
                    resp_timer--;
                    if (resp_timer == 0) begin
                        bus.mem_resp_valid = 1'b1;
                        bus.mem_resp_data  = pend_addr;
                        resp_cnt++;
                        if (resp_cnt == 1) first_resp_cyc = cyc;
                        last_resp_cyc = cyc;
                    end
                end
                bus.mem_req_ready = 1'b0;
                if (bus.mem_req_valid) begin
                    check_eq("one_outstanding", resp_timer, 0);
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                    if (wait_cnt == 0) held_addr = bus.mem_req_addr;
                    else check_eq("req_addr_stable", bus.mem_req_addr, held_addr);
                    if (wait_cnt >= ready_delay) begin
                        bus.mem_req_ready = 1'b1;
                        if (req_cnt < 16) req_log[req_cnt] = bus.mem_req_addr;
                        req_cnt++;
                        pend_addr  = bus.mem_req_addr;
                        resp_timer = resp_delay + 1;
                        wait_cnt   = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    int          fill_cnt, crit_cnt, crit_cyc;
    logic [31:0] crit_dat;

    initial begin
        fill_cnt = 0; crit_cnt = 0; crit_cyc = -1; crit_dat = '0;
        forever begin
            @(negedge clk);
            if (bus.fill_valid) fill_cnt++;
            if (bus.crit_valid) begin
                crit_cnt++;
                crit_cyc = cyc;
                crit_dat = bus.crit_instr;
            end
        end
    end

    task automatic clear_log();
        req_cnt = 0; resp_cnt = 0;
        first_req_cyc = -1; first_resp_cyc = -1; last_resp_cyc = -1;
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
    task automatic do_miss(input logic [31:0] addr, input logic [3:0] sv, input logic [1:0] exp_way,
                           input bit hold_busy, input int rdly, input int pdly);
        logic [31:0]  base;
        logic [1:0]   woff, start;
        logic [127:0] exp_data;
        int           t0, fcyc, n, fills0, crits0;
        base  = {addr[31:4], 4'h0};
        woff  = addr[3:2];
        start = CWF ? woff : 2'd0;
        exp_data = {base + 32'd12, base + 32'd8, base + 32'd4, base};
        ready_delay = rdly;
        resp_delay  = pdly;
        clear_log();
        fills0 = fill_cnt;
        crits0 = crit_cnt;

        bus.miss_req  = 1'b1;
        bus.miss_addr = addr;
        bus.set_valid = sv;
        check_eq("miss_ready_idle", bus.miss_ready, 1'b1);
        t0 = cyc;
        @(negedge clk);
        if (hold_busy) begin
            bus.miss_addr = 32'hDEAD_BEEF;
            bus.set_valid = 4'h0;
        end else begin
            bus.miss_req  = 1'b0;
            bus.miss_addr = '0;
        end

        n = 0;
        while (!bus.fill_valid && n < 400) begin
            if (hold_busy) check_eq("miss_ready_busy", bus.miss_ready, 1'b0);
            @(negedge clk);
            n++;
        end
        fcyc = cyc;
        bus.miss_req = 1'b0;
        check_eq("fill_seen", bus.fill_valid, 1'b1);
        check_eq("fill_index", bus.fill_index, addr[5:4]);
        check_eq("fill_tag", bus.fill_tag, addr[31:6]);
        check_eq("fill_way", bus.fill_way, exp_way);
        check_eq("fill_data", bus.fill_data, exp_data);
        check_eq("fill_after_last_resp", fcyc, last_resp_cyc + 1);
        check_eq("req_count", req_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] k;
            k = start + 2'(i);
            check_eq("req_addr", req_log[i], base + {28'd0, k, 2'b00});
        end
        if (rdly == 0 && pdly == 0) begin
            check_eq("lat_first_req", first_req_cyc - t0, 1);
            check_eq("lat_fill", fcyc - t0, 9);
        end

        #1;
        check_eq("crit_count", crit_cnt - crits0, 1);
        check_eq("crit_instr", crit_dat, base + {28'd0, woff, 2'b00});
        check_eq("crit_cycle", crit_cyc, CWF ? first_resp_cyc + 1 : fcyc);

        @(negedge clk);
        check_eq("fill_pulse_one", bus.fill_valid, 1'b0);
        check_eq("fill_count", fill_cnt - fills0, 1);
        check_eq("miss_ready_after", bus.miss_ready, 1'b1);
    endtask

    initial begin
        int n, fills0;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.miss_req  = 1'b0;
        bus.miss_addr = '0;
        bus.set_valid = '0;
        clear_log();

        repeat (3) @(negedge clk);
        check_eq("rst_miss_ready", bus.miss_ready, 1'b1);
        check_eq("rst_req_valid", bus.mem_req_valid, 1'b0);
        check_eq("rst_req_addr", bus.mem_req_addr, 32'h0);
        check_eq("rst_fill_valid", bus.fill_valid, 1'b0);
        check_eq("rst_fill_data", bus.fill_data, 128'h0);
        check_eq("rst_crit_valid", bus.crit_valid, 1'b0);
        #1 reset = 1'b0;
        @(negedge clk);

        // Reference miss: index 3, tag 0x48, words 0x1230..0x123C.
        do_miss(32'h0000_1234, 4'b0000, 2'd0, 1'b0, 0, 0);

        // Round-robin on full set 3, with set 0 interleaved.
        do_miss(32'h0000_2030, 4'b1111, 2'd0, 1'b0, 0, 0);
        do_miss(32'h0000_3034, 4'b1111, 2'd1, 1'b0, 0, 0);
        do_miss(32'h0000_403C, 4'b1111, 2'd2, 1'b0, 0, 0);
        do_miss(32'h0000_5008, 4'b1111, 2'd0, 1'b0, 0, 0);
        do_miss(32'h0000_6038, 4'b1111, 2'd3, 1'b0, 0, 0);
        do_miss(32'h0000_7030, 4'b1111, 2'd0, 1'b0, 0, 0);
        do_miss(32'h0000_8004, 4'b1111, 2'd1, 1'b0, 0, 0);
        do_miss(32'h0000_9134, 4'b1011, 2'd2, 1'b0, 0, 0);
        do_miss(32'h0000_A030, 4'b1111, 2'd1, 1'b0, 0, 0);

        // Slow memory, miss_req held high with a changing address while busy.
        do_miss(32'h0000_ABC8, 4'b0001, 2'd1, 1'b1, 5, 3);

        // Reset after two responses abandons the fill.
        clear_log();
        ready_delay = 0;
        resp_delay  = 0;
        fills0 = fill_cnt;
        bus.miss_req  = 1'b1;
        bus.miss_addr = 32'h0000_0100;
        bus.set_valid = 4'b0000;
        @(negedge clk);
        bus.miss_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (resp_cnt < 2 && n < 100);
        check_eq("rst_mid_two_resp", resp_cnt, 2);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_miss_ready", bus.miss_ready, 1'b1);
        check_eq("rst_mid_req_valid", bus.mem_req_valid, 1'b0);
        check_eq("rst_mid_fill_valid", bus.fill_valid, 1'b0);
        #1 reset = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("rst_mid_no_fill", fill_cnt - fills0, 0);
        check_eq("rst_mid_no_more_req", req_cnt, 2);

        // Pointers were cleared by reset, so a full set 3 picks way 0 again.
        do_miss(32'h0000_1230, 4'b1111, 2'd0, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
